// File: rtl/id_ex_alu_issue.sv
// ID/EX issue register for the EX-stage ALU: decodes the ID instruction into
// an ALU op code plus A/B operands and registers them with stall/flush control.
module id_ex_alu_issue #(
  parameter int unsigned RESET_PC_TAG = 0  // reserved, keep at 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [3:0]  ex_ALUctr,
  output logic [4:0]  ex_wreg_addr,
  output logic        ex_wreg_en,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CTRW  = 4;
  localparam int unsigned REGW  = 5;
  localparam int unsigned OPW   = 6;
  localparam int unsigned IMMW  = 16;

  // ALU operation codes as understood by the EX-stage ALU
  localparam logic [CTRW-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRW-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRW-1:0] ALU_OR   = 4'b0010;
  localparam logic [CTRW-1:0] ALU_AND  = 4'b0011;
  localparam logic [CTRW-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRW-1:0] ALU_NOR  = 4'b0101;
  localparam logic [CTRW-1:0] ALU_SLL  = 4'b0110;
  localparam logic [CTRW-1:0] ALU_SLLV = 4'b0111;
  localparam logic [CTRW-1:0] ALU_SRA  = 4'b1000;
  localparam logic [CTRW-1:0] ALU_SRAV = 4'b1001;
  localparam logic [CTRW-1:0] ALU_SRL  = 4'b1010;
  localparam logic [CTRW-1:0] ALU_SRLV = 4'b1011;
  localparam logic [CTRW-1:0] ALU_SLT  = 4'b1100;
  localparam logic [CTRW-1:0] ALU_SLTU = 4'b1101;

  // Major opcodes
  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPW-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPW-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPW-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPW-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPW-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [OPW-1:0] FN_SLL  = 6'h00;
  localparam logic [OPW-1:0] FN_SRL  = 6'h02;
  localparam logic [OPW-1:0] FN_SRA  = 6'h03;
  localparam logic [OPW-1:0] FN_SLLV = 6'h04;
  localparam logic [OPW-1:0] FN_SRLV = 6'h06;
  localparam logic [OPW-1:0] FN_SRAV = 6'h07;
  localparam logic [OPW-1:0] FN_ADD  = 6'h20;
  localparam logic [OPW-1:0] FN_ADDU = 6'h21;
  localparam logic [OPW-1:0] FN_SUB  = 6'h22;
  localparam logic [OPW-1:0] FN_SUBU = 6'h23;
  localparam logic [OPW-1:0] FN_AND  = 6'h24;
  localparam logic [OPW-1:0] FN_OR   = 6'h25;
  localparam logic [OPW-1:0] FN_XOR  = 6'h26;
  localparam logic [OPW-1:0] FN_NOR  = 6'h27;
  localparam logic [OPW-1:0] FN_SLT  = 6'h2A;
  localparam logic [OPW-1:0] FN_SLTU = 6'h2B;

  // Instruction fields
  logic [OPW-1:0]  w_op;
  logic [OPW-1:0]  w_funct;
  logic [REGW-1:0] w_rt;
  logic [REGW-1:0] w_rd;
  logic [REGW-1:0] w_shamt;
  logic [IMMW-1:0] w_imm;
  logic [XLEN-1:0] w_imm_sext;
  logic [XLEN-1:0] w_imm_zext;
  logic [XLEN-1:0] w_shamt_zext;
  logic [REGW-1:0] w_unused_rs_field;

  assign w_op              = id_instr[31:26];
  assign w_unused_rs_field = id_instr[25:21];  // rs value arrives already forwarded
  assign w_rt              = id_instr[20:16];
  assign w_rd              = id_instr[15:11];
  assign w_shamt           = id_instr[10:6];
  assign w_funct           = id_instr[5:0];
  assign w_imm             = id_instr[15:0];
  assign w_imm_sext        = {{(XLEN-IMMW){w_imm[IMMW-1]}}, w_imm};
  assign w_imm_zext        = {{(XLEN-IMMW){1'b0}}, w_imm};
  assign w_shamt_zext      = {{(XLEN-REGW){1'b0}}, w_shamt};

  // Decoded next-EX values
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [CTRW-1:0] w_ctr;
  logic [REGW-1:0] w_waddr;
  logic            w_writes;
  logic            w_mem_rd;
  logic            w_mem_wr;
  logic [XLEN-1:0] w_store_data;
  logic            w_illegal;
  logic            w_wreg_en;

  // Instruction decode: ALU op code, operand selection and side effects
  always_comb begin
    w_a          = id_rs_val;
    w_b          = id_rt_val;
    w_ctr        = ALU_ADD;
    w_waddr      = '0;
    w_writes     = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_store_data = '0;
    w_illegal    = 1'b0;

    case (w_op)
      OP_RTYPE: begin
        w_waddr  = w_rd;
        w_writes = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_ctr = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctr = ALU_SUB;
          FN_AND:          w_ctr = ALU_AND;
          FN_OR:           w_ctr = ALU_OR;
          FN_XOR:          w_ctr = ALU_XOR;
          FN_NOR:          w_ctr = ALU_NOR;
          FN_SLT:          w_ctr = ALU_SLT;
          FN_SLTU:         w_ctr = ALU_SLTU;
          FN_SLLV:         w_ctr = ALU_SLLV;
          FN_SRLV:         w_ctr = ALU_SRLV;
          FN_SRAV:         w_ctr = ALU_SRAV;
          // Constant shifts: value to shift on A, amount on B
          FN_SLL: begin
            w_ctr = ALU_SLL;
            w_a   = id_rt_val;
            w_b   = w_shamt_zext;
          end
          FN_SRL: begin
            w_ctr = ALU_SRL;
            w_a   = id_rt_val;
            w_b   = w_shamt_zext;
          end
          FN_SRA: begin
            w_ctr = ALU_SRA;
            w_a   = id_rt_val;
            w_b   = w_shamt_zext;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        w_ctr    = ALU_ADD;
        w_b      = w_imm_sext;
        w_waddr  = w_rt;
        w_writes = 1'b1;
      end
      OP_SLTI: begin
        w_ctr    = ALU_SLT;
        w_b      = w_imm_sext;
        w_waddr  = w_rt;
        w_writes = 1'b1;
      end
      OP_SLTIU: begin
        w_ctr    = ALU_SLTU;
        w_b      = w_imm_sext;
        w_waddr  = w_rt;
        w_writes = 1'b1;
      end
      OP_ANDI: begin
        w_ctr    = ALU_AND;
        w_b      = w_imm_zext;
        w_waddr  = w_rt;
        w_writes = 1'b1;
      end
      OP_ORI: begin
        w_ctr    = ALU_OR;
        w_b      = w_imm_zext;
        w_waddr  = w_rt;
        w_writes = 1'b1;
      end
      OP_XORI: begin
        w_ctr    = ALU_XOR;
        w_b      = w_imm_zext;
        w_waddr  = w_rt;
        w_writes = 1'b1;
      end
      OP_LUI: begin
        w_ctr    = ALU_ADD;
        w_a      = {w_imm, {(XLEN-IMMW){1'b0}}};
        w_b      = '0;
        w_waddr  = w_rt;
        w_writes = 1'b1;
      end
      OP_LW: begin
        w_ctr    = ALU_ADD;
        w_b      = w_imm_sext;
        w_waddr  = w_rt;
        w_writes = 1'b1;
        w_mem_rd = 1'b1;
      end
      OP_SW: begin
        w_ctr        = ALU_ADD;
        w_b          = w_imm_sext;
        w_mem_wr     = 1'b1;
        w_store_data = id_rt_val;
      end
      default: w_illegal = 1'b1;
    endcase

    // Unsupported encodings issue as an inert add of 0+0 flagged illegal
    if (w_illegal) begin
      w_a          = '0;
      w_b          = '0;
      w_ctr        = ALU_ADD;
      w_waddr      = '0;
      w_writes     = 1'b0;
      w_mem_rd     = 1'b0;
      w_mem_wr     = 1'b0;
      w_store_data = '0;
    end
  end

  // Register-file write is suppressed for $0 but the address is kept
  assign w_wreg_en = w_writes && (w_waddr != '0);

  // ID/EX pipeline register
  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [CTRW-1:0] r_ctr;
  logic [REGW-1:0] r_waddr;
  logic            r_wreg_en;
  logic            r_mem_rd;
  logic            r_mem_wr;
  logic [XLEN-1:0] r_store_data;
  logic            r_illegal;

  // Priority flush > stall > load; invalid ID slot loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_ctr        <= '0;
      r_waddr      <= '0;
      r_wreg_en    <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_store_data <= '0;
      r_illegal    <= 1'(RESET_PC_TAG);
    end else if (flush || (!stall && !id_valid)) begin
      r_valid      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_ctr        <= '0;
      r_waddr      <= '0;
      r_wreg_en    <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_store_data <= '0;
      r_illegal    <= 1'b0;
    end else if (!stall) begin
      r_valid      <= 1'b1;
      r_a          <= w_a;
      r_b          <= w_b;
      r_ctr        <= w_ctr;
      r_waddr      <= w_waddr;
      r_wreg_en    <= w_wreg_en;
      r_mem_rd     <= w_mem_rd;
      r_mem_wr     <= w_mem_wr;
      r_store_data <= w_store_data;
      r_illegal    <= w_illegal;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_A          = r_a;
  assign ex_B          = r_b;
  assign ex_ALUctr     = r_ctr;
  assign ex_wreg_addr  = r_waddr;
  assign ex_wreg_en    = r_wreg_en;
  assign ex_mem_rd     = r_mem_rd;
  assign ex_mem_wr     = r_mem_wr;
  assign ex_store_data = r_store_data;
  assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: directed test-plan steps followed by
// randomized traffic, checked against a behavioural model of the EX slot.
module tb_id_ex_alu_issue;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  wa;
    logic        we;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic        il;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_rs_val = '0;
  logic [31:0] id_rt_val = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [3:0]  ex_ALUctr;
  logic [4:0]  ex_wreg_addr;
  logic        ex_wreg_en;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [31:0] ex_store_data;
  logic        ex_illegal;

  int n_cmp = 0;
  int n_err = 0;
  ex_t model = '0;

  logic [5:0] rfn_list [0:13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h07};
  logic [5:0] iop_list [0:11] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                  6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h3F};

  id_ex_alu_issue dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_ALUctr(ex_ALUctr),
    .ex_wreg_addr(ex_wreg_addr), .ex_wreg_en(ex_wreg_en), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt,
                                        input int imm);
    itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // What the EX slot should hold for a valid ID instruction, from the ISA rules
  function automatic ex_t ref_issue(input logic [31:0] ins, input logic [31:0] rs,
                                    input logic [31:0] rt);
    ex_t e;
    int  code;
    int  op;
    int  fn;
    int  dst;
    logic [31:0] se;
    logic [31:0] ze;
    logic [15:0] imm;
    logic writes;
    e      = '0;
    op     = int'(ins[31:26]);
    fn     = int'(ins[5:0]);
    imm    = ins[15:0];
    se     = 32'($signed(imm));
    ze     = 32'(imm);
    code   = -1;
    writes = 1'b1;
    e.a    = rs;
    e.b    = rt;
    if (op == 0) begin
      dst = int'(ins[15:11]);
      case (fn)
        'h20, 'h21: code = 0;
        'h22, 'h23: code = 1;
        'h25: code = 2;
        'h24: code = 3;
        'h26: code = 4;
        'h27: code = 5;
        'h2A: code = 12;
        'h2B: code = 13;
        'h04: code = 7;
        'h07: code = 9;
        'h06: code = 11;
        'h00: code = 6;
        'h03: code = 8;
        'h02: code = 10;
        default: code = -1;
      endcase
      if (fn == 'h00 || fn == 'h02 || fn == 'h03) begin
        e.a = rt;
        e.b = 32'(ins[10:6]);
      end
    end else begin
      dst = int'(ins[20:16]);
      case (op)
        'h08, 'h09: begin code = 0;  e.b = se; end
        'h0A:       begin code = 12; e.b = se; end
        'h0B:       begin code = 13; e.b = se; end
        'h0C:       begin code = 3;  e.b = ze; end
        'h0D:       begin code = 2;  e.b = ze; end
        'h0E:       begin code = 4;  e.b = ze; end
        'h0F:       begin code = 0;  e.a = {imm, 16'h0}; e.b = 0; end
        'h23:       begin code = 0;  e.b = se; e.mr = 1'b1; end
        'h2B:       begin code = 0;  e.b = se; e.mw = 1'b1; e.sd = rt; writes = 1'b0; end
        default:    code = -1;
      endcase
    end
    if (code < 0) begin
      e    = '0;
      e.il = 1'b1;
    end else begin
      e.c  = 4'(code);
      e.wa = writes ? 5'(dst) : 5'd0;
      e.we = writes && (dst != 0);
    end
    e.v = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(model.v));
    chk({tag, ".A"}, ex_A, model.a);
    chk({tag, ".B"}, ex_B, model.b);
    chk({tag, ".ALUctr"}, 32'(ex_ALUctr), 32'(model.c));
    chk({tag, ".waddr"}, 32'(ex_wreg_addr), 32'(model.wa));
    chk({tag, ".wen"}, 32'(ex_wreg_en), 32'(model.we));
    chk({tag, ".mem_rd"}, 32'(ex_mem_rd), 32'(model.mr));
    chk({tag, ".mem_wr"}, 32'(ex_mem_wr), 32'(model.mw));
    chk({tag, ".sdata"}, ex_store_data, model.sd);
    chk({tag, ".illegal"}, 32'(ex_illegal), 32'(model.il));
  endtask

  // Drive one cycle of ID inputs, advance the model at the edge, check after it
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic st, input logic fl);
    id_valid  = v;
    id_instr  = ins;
    id_rs_val = rs;
    id_rt_val = rt;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    if (fl)       model = '0;
    else if (st)  model = model;
    else if (v)   model = ref_issue(ins, rs, rt);
    else          model = '0;
    #1;
    chk_all(tag);
  endtask

  initial begin
    ex_t held;
    // Reset asserted mid-cycle clears outputs immediately
    #3;
    rst_n = 1'b0;
    #1;
    model = '0;
    chk_all("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    step("reset_idle", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    step("add", 1'b1, 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b0);
    chk("add_A_const", ex_A, 32'd5);
    chk("add_B_const", ex_B, 32'd7);
    chk("add_waddr_const", 32'(ex_wreg_addr), 32'd3);

    step("sll", 1'b1, 32'h000220C0, 32'h55, 32'h1, 1'b0, 1'b0);
    chk("sll_B_const", ex_B, 32'd3);
    chk("sll_ctr_const", 32'(ex_ALUctr), 32'b0110);

    step("srav", 1'b1, 32'h00222007, 32'd4, 32'h80000000, 1'b0, 1'b0);
    chk("srav_ctr_const", 32'(ex_ALUctr), 32'b1001);

    step("andi", 1'b1, itype('h0C, 1, 5, 'hFFFF), 32'h1234, 32'h0, 1'b0, 1'b0);
    chk("andi_B_const", ex_B, 32'h0000FFFF);
    step("sltiu", 1'b1, itype('h0B, 1, 5, 'hFFFF), 32'h1234, 32'h0, 1'b0, 1'b0);
    chk("sltiu_B_const", ex_B, 32'hFFFFFFFF);
    step("lui", 1'b1, itype('h0F, 0, 6, 'h1234), 32'h9, 32'h9, 1'b0, 1'b0);
    chk("lui_A_const", ex_A, 32'h12340000);
    step("lw", 1'b1, itype('h23, 3, 8, 'h8000), 32'h1000, 32'h7, 1'b0, 1'b0);
    step("addi_r0", 1'b1, itype('h08, 3, 0, 'h0010), 32'h1, 32'h2, 1'b0, 1'b0);
    chk("addi_r0_wen_const", 32'(ex_wreg_en), 32'd0);

    // Stall holds the EX slot while ID keeps changing
    step("stall_load", 1'b1, 32'h00221820, 32'd11, 32'd22, 1'b0, 1'b0);
    held = model;
    for (int i = 0; i < 3; i++)
      step("stall_hold", 1'b1, rtype(i, i + 1, 9, 0, 'h22), 32'(i * 3), 32'hDEAD, 1'b1, 1'b0);
    chk("stall_A_const", ex_A, held.a);
    step("stall_flush", 1'b1, 32'h00221820, 32'd1, 32'd2, 1'b1, 1'b1);
    chk("flush_valid_const", 32'(ex_valid), 32'd0);

    step("illegal_op", 1'b1, 32'hFC221820, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("illegal_const", 32'(ex_illegal), 32'd1);
    step("illegal_fn", 1'b1, rtype(1, 2, 3, 0, 'h28), 32'd1, 32'd2, 1'b0, 1'b0);

    step("sw", 1'b1, 32'hAC22FFFC, 32'h100, 32'hAB, 1'b0, 1'b0);
    chk("sw_B_const", ex_B, 32'hFFFFFFFC);
    chk("sw_sdata_const", ex_store_data, 32'hAB);

    // Reset during a stall discards the held instruction
    step("pre_rst_stall", 1'b1, 32'h00221820, 32'd5, 32'd6, 1'b0, 1'b0);
    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    model = '0;
    chk_all("reset_in_stall");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_stall", 1'b1, 32'h00221820, 32'd5, 32'd6, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      int k;
      k = int'($urandom_range(0, 9));
      if (k < 5)
        ins = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), int'(rfn_list[$urandom_range(0, 13)]));
      else if (k < 8)
        ins = itype(int'(iop_list[$urandom_range(0, 11)]), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 65535));
      else if (k == 8)
        ins = $urandom;
      else
        ins = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 63));
      step("random", ($urandom_range(0, 9) != 0), ins, $urandom, $urandom,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
